// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants, select encodings and stage-field types for the
// 5-stage RV32I pipeline controller.
package pipe_ctrl_pkg;

  localparam int OP_W = 5;
  localparam int F3_W = 3;

  // opcode[6:2] values
  localparam logic [OP_W-1:0] OP_R      = 5'b01100;
  localparam logic [OP_W-1:0] OP_IMM    = 5'b00100;
  localparam logic [OP_W-1:0] OP_LOAD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_STORE  = 5'b01000;
  localparam logic [OP_W-1:0] OP_BRANCH = 5'b11000;
  localparam logic [OP_W-1:0] OP_JAL    = 5'b11011;
  localparam logic [OP_W-1:0] OP_JALR   = 5'b11001;
  localparam logic [OP_W-1:0] OP_LUI    = 5'b01101;
  localparam logic [OP_W-1:0] OP_AUIPC  = 5'b00101;

  // E-stage operand source encodings
  localparam logic [1:0] SEL_W  = 2'd0;
  localparam logic [1:0] SEL_M  = 2'd1;
  localparam logic [1:0] SEL_RF = 2'd2;

  // Decoded control fields carried down the pipe with each instruction
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [F3_W-1:0] f3;
    logic            f7;
  } ctrl_fields_t;

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

  // True for opcodes that produce a register result (rd != 0 checked by caller)
  function automatic logic op_writes_rd(input logic [OP_W-1:0] op);
    return !(op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic [3:0] store_be(input logic [F3_W-1:0] f3);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001;
      3'b001:  be = 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stage_reg.sv
// One pipeline stage of control state: valid bit plus decoded fields.
// en = 0 freezes the stage; bubble clears only the valid bit so the fields
// still follow the upstream instruction.
module stage_ctrl_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  bubble,
  input  logic                  d_valid,
  input  ctrl_fields_t          d_ctrl,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  output logic                  q_valid,
  output ctrl_fields_t          q_ctrl,
  output logic [REG_ADDR_W-1:0] q_rd,
  output logic [REG_ADDR_W-1:0] q_rs1,
  output logic [REG_ADDR_W-1:0] q_rs2
);

  // Capture upstream stage when enabled; async clear to an empty stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_rd    <= '0;
      q_rs1   <= '0;
      q_rs2   <= '0;
    end else if (en) begin
      q_valid <= d_valid & ~bubble;
      q_ctrl  <= d_ctrl;
      q_rd    <= d_rd;
      q_rs1   <= d_rs1;
      q_rs2   <= d_rs2;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller for the 5-stage RV32I core: tracks E/M/W control
// fields, produces forwarding selects, load-use/RAW stalls, control-transfer
// flushes, store byte enables, writeback control and event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FWD_EN         = 1,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  D_valid,
  input  logic [4:0]            D_op,
  input  logic [2:0]            D_f3,
  input  logic                  D_f7,
  input  logic [REG_ADDR_W-1:0] D_rd,
  input  logic [REG_ADDR_W-1:0] D_rs1,
  input  logic [REG_ADDR_W-1:0] D_rs2,
  input  logic                  b,
  output logic                  stall,
  output logic                  flush,
  output logic                  next_pc_sel,
  output logic                  D_rs1_data_sel,
  output logic                  D_rs2_data_sel,
  output logic [1:0]            E_rs1_data_sel,
  output logic [1:0]            E_rs2_data_sel,
  output logic                  E_alu_op1_sel,
  output logic                  E_alu_op2_sel,
  output logic                  E_jb_op1_sel,
  output logic [4:0]            E_op_out,
  output logic [2:0]            E_f3_out,
  output logic                  E_f7_out,
  output logic [3:0]            M_dm_w_en,
  output logic                  W_wb_en,
  output logic [REG_ADDR_W-1:0] W_rd_index,
  output logic [2:0]            W_f3,
  output logic                  W_wb_data_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic                  e_valid, m_valid, w_valid;
  ctrl_fields_t          d_ctrl, e_ctrl, m_ctrl, w_ctrl;
  logic [REG_ADDR_W-1:0] e_rd, e_rs1, e_rs2;
  logic [REG_ADDR_W-1:0] m_rd, m_rs1, m_rs2;
  logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
  logic                  e_wr, m_wr, w_wr;
  logic                  d_use1, d_use2, hit_e, hit_m;
  logic                  load_use, raw_hazard, ctl_xfer;
  logic                  adv, e_bubble;
  logic                  unused_fields;

  assign d_ctrl   = '{op: D_op, f3: D_f3, f7: D_f7};
  assign adv      = ~hold;
  assign e_bubble = stall | flush;

  stage_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_e_stage (
    .clk(clk), .rst_n(rst_n), .en(adv), .bubble(e_bubble),
    .d_valid(D_valid), .d_ctrl(d_ctrl), .d_rd(D_rd), .d_rs1(D_rs1), .d_rs2(D_rs2),
    .q_valid(e_valid), .q_ctrl(e_ctrl), .q_rd(e_rd), .q_rs1(e_rs1), .q_rs2(e_rs2)
  );

  stage_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_m_stage (
    .clk(clk), .rst_n(rst_n), .en(adv), .bubble(1'b0),
    .d_valid(e_valid), .d_ctrl(e_ctrl), .d_rd(e_rd), .d_rs1(e_rs1), .d_rs2(e_rs2),
    .q_valid(m_valid), .q_ctrl(m_ctrl), .q_rd(m_rd), .q_rs1(m_rs1), .q_rs2(m_rs2)
  );

  stage_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_w_stage (
    .clk(clk), .rst_n(rst_n), .en(adv), .bubble(1'b0),
    .d_valid(m_valid), .d_ctrl(m_ctrl), .d_rd(m_rd), .d_rs1(m_rs1), .d_rs2(m_rs2),
    .q_valid(w_valid), .q_ctrl(w_ctrl), .q_rd(w_rd), .q_rs1(w_rs1), .q_rs2(w_rs2)
  );

  // Source indices of later stages are carried only for visibility
  assign unused_fields = ^{m_rs1, m_rs2, w_rs1, w_rs2, m_ctrl.f7, w_ctrl.f7};

  assign e_wr = e_valid & op_writes_rd(e_ctrl.op) & (e_rd != '0);
  assign m_wr = m_valid & op_writes_rd(m_ctrl.op) & (m_rd != '0);
  assign w_wr = w_valid & op_writes_rd(w_ctrl.op) & (w_rd != '0);

  assign d_use1 = D_valid & uses_rs1(D_op);
  assign d_use2 = D_valid & uses_rs2(D_op);
  assign hit_e  = (d_use1 && D_rs1 == e_rd) || (d_use2 && D_rs2 == e_rd);
  assign hit_m  = (d_use1 && D_rs1 == m_rd) || (d_use2 && D_rs2 == m_rd);

  // Hazard and control-transfer detection; flush wins over stall
  always_comb begin
    load_use   = e_wr & (e_ctrl.op == OP_LOAD) & hit_e;
    if (LOAD_STALL_CYC == 2)
      load_use = load_use | (m_wr & (m_ctrl.op == OP_LOAD) & hit_m);
    raw_hazard = 1'b0;
    if (FWD_EN == 0)
      raw_hazard = (e_wr & hit_e) | (m_wr & hit_m);
    ctl_xfer   = e_valid & ((e_ctrl.op == OP_JAL) || (e_ctrl.op == OP_JALR) ||
                            ((e_ctrl.op == OP_BRANCH) && b));
  end

  assign flush       = ctl_xfer;
  assign next_pc_sel = ~ctl_xfer;
  assign stall       = (load_use | raw_hazard) & ~ctl_xfer;

  // E operand sources: M result beats W result; regfile when nothing matches.
  assign E_rs1_data_sel = (FWD_EN == 0)                ? SEL_RF :
                          (m_wr && e_rs1 == m_rd)      ? SEL_M  :
                          (w_wr && e_rs1 == w_rd)      ? SEL_W  : SEL_RF;
  assign E_rs2_data_sel = (FWD_EN == 0)                ? SEL_RF :
                          (m_wr && e_rs2 == m_rd)      ? SEL_M  :
                          (w_wr && e_rs2 == w_rd)      ? SEL_W  : SEL_RF;

  // The D-stage write-through bypass stays active without forwarding: the
  // RAW stall releases as soon as the producer reaches W, so D must take W data.
  assign D_rs1_data_sel = w_wr && (D_rs1 == w_rd);
  assign D_rs2_data_sel = w_wr && (D_rs2 == w_rd);

  // Operand mux selects decoded from the E-stage opcode (empty stage = all 0)
  always_comb begin
    E_alu_op1_sel = 1'b0;
    E_alu_op2_sel = 1'b0;
    E_jb_op1_sel  = 1'b0;
    if (e_valid) begin
      case (e_ctrl.op)
        OP_IMM, OP_LOAD, OP_STORE: E_alu_op2_sel = 1'b1;
        OP_BRANCH:                 E_jb_op1_sel  = 1'b1;
        OP_JALR:                   E_alu_op1_sel = 1'b1;
        OP_JAL: begin
          E_alu_op1_sel = 1'b1;
          E_jb_op1_sel  = 1'b1;
        end
        OP_AUIPC: begin
          E_alu_op1_sel = 1'b1;
          E_alu_op2_sel = 1'b1;
        end
        OP_LUI:                    E_alu_op2_sel = 1'b1;
        default: ;
      endcase
    end
  end

  assign E_op_out = e_ctrl.op;
  assign E_f3_out = e_ctrl.f3;
  assign E_f7_out = e_ctrl.f7;

  assign M_dm_w_en = (m_valid && m_ctrl.op == OP_STORE) ? store_be(m_ctrl.f3) : 4'b0000;

  assign W_wb_en       = w_wr;
  assign W_rd_index    = w_rd;
  assign W_f3          = w_ctrl.f3;
  assign W_wb_data_sel = w_valid && (w_ctrl.op == OP_LOAD);

  // Saturating stall/flush event counters, frozen while hold is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (adv) begin
      if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances share the D-stage
// inputs (0: forwarding, 1-cycle load-use; 1: 2-cycle load-use;
// 2: no forwarding with a 2-bit counter for saturation).
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk, rst_n, hold, D_valid, D_f7, b;
  logic [4:0] D_op, D_rd, D_rs1, D_rs2;
  logic [2:0] D_f3;

  logic       stall_o[3], flush_o[3], npc_o[3], d1_o[3], d2_o[3];
  logic [1:0] e1_o[3], e2_o[3];
  logic       alu1_o[3], alu2_o[3], jb_o[3], ef7_o[3], wbe_o[3], wbsel_o[3];
  logic [4:0] eop_o[3], wrd_o[3];
  logic [2:0] ef3_o[3], wf3_o[3];
  logic [3:0] dmw_o[3];
  logic [31:0] scnt_a[2], fcnt_a[2];
  logic [1:0]  scnt2, fcnt2;

  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYC(g + 1), .FWD_EN(1), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .D_valid(D_valid), .D_op(D_op), .D_f3(D_f3),
      .D_f7(D_f7), .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2), .b(b),
      .stall(stall_o[g]), .flush(flush_o[g]), .next_pc_sel(npc_o[g]),
      .D_rs1_data_sel(d1_o[g]), .D_rs2_data_sel(d2_o[g]),
      .E_rs1_data_sel(e1_o[g]), .E_rs2_data_sel(e2_o[g]),
      .E_alu_op1_sel(alu1_o[g]), .E_alu_op2_sel(alu2_o[g]), .E_jb_op1_sel(jb_o[g]),
      .E_op_out(eop_o[g]), .E_f3_out(ef3_o[g]), .E_f7_out(ef7_o[g]),
      .M_dm_w_en(dmw_o[g]), .W_wb_en(wbe_o[g]), .W_rd_index(wrd_o[g]), .W_f3(wf3_o[g]),
      .W_wb_data_sel(wbsel_o[g]), .stall_cnt(scnt_a[g]), .flush_cnt(fcnt_a[g])
    );
  end

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYC(1), .FWD_EN(0), .CNT_W(2)) u_dut_nf (
    .clk(clk), .rst_n(rst_n), .hold(hold), .D_valid(D_valid), .D_op(D_op), .D_f3(D_f3),
    .D_f7(D_f7), .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2), .b(b),
    .stall(stall_o[2]), .flush(flush_o[2]), .next_pc_sel(npc_o[2]),
    .D_rs1_data_sel(d1_o[2]), .D_rs2_data_sel(d2_o[2]),
    .E_rs1_data_sel(e1_o[2]), .E_rs2_data_sel(e2_o[2]),
    .E_alu_op1_sel(alu1_o[2]), .E_alu_op2_sel(alu2_o[2]), .E_jb_op1_sel(jb_o[2]),
    .E_op_out(eop_o[2]), .E_f3_out(ef3_o[2]), .E_f7_out(ef7_o[2]),
    .M_dm_w_en(dmw_o[2]), .W_wb_en(wbe_o[2]), .W_rd_index(wrd_o[2]), .W_f3(wf3_o[2]),
    .W_wb_data_sel(wbsel_o[2]), .stall_cnt(scnt2), .flush_cnt(fcnt2)
  );

  typedef struct {
    logic       vld;
    logic [4:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rd, rs1, rs2;
    logic       bb;
    logic       stall, flush, npc;
    logic [1:0] e1, e2;
    logic       d1;
    logic [3:0] dmw;
    logic       wbe;
    logic [2:0] osel;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic vld, input logic [4:0] op, input logic [2:0] f3,
                              input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic bb, input logic st,
                              input logic fl, input logic npc, input logic [1:0] e1,
                              input logic [1:0] e2, input logic d1, input logic [3:0] dmw,
                              input logic wbe, input logic [2:0] osel);
    vec_t v;
    v.vld = vld; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.bb = bb; v.stall = st; v.flush = fl; v.npc = npc; v.e1 = e1; v.e2 = e2; v.d1 = d1;
    v.dmw = dmw; v.wbe = wbe; v.osel = osel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3,
                       input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic bb, input logic hh);
    D_valid = v; D_op = op; D_f3 = f3; D_f7 = f7; D_rd = rd; D_rs1 = rs1; D_rs2 = rs2;
    b = bb; hold = hh;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s[%0d] stall", tag, k), stall_o[k], 0);
      chk($sformatf("%s[%0d] flush", tag, k), flush_o[k], 0);
      chk($sformatf("%s[%0d] npc", tag, k), npc_o[k], 1);
      chk($sformatf("%s[%0d] e1", tag, k), e1_o[k], SEL_RF);
      chk($sformatf("%s[%0d] e2", tag, k), e2_o[k], SEL_RF);
      chk($sformatf("%s[%0d] d1d2", tag, k), {d1_o[k], d2_o[k]}, 0);
      chk($sformatf("%s[%0d] osel", tag, k), {alu1_o[k], alu2_o[k], jb_o[k]}, 0);
      chk($sformatf("%s[%0d] eop", tag, k), {eop_o[k], ef3_o[k], ef7_o[k]}, 0);
      chk($sformatf("%s[%0d] dmw", tag, k), dmw_o[k], 0);
      chk($sformatf("%s[%0d] wb", tag, k), {wbe_o[k], wbsel_o[k], wrd_o[k], wf3_o[k]}, 0);
    end
    chk({tag, " cnt0"}, scnt_a[0] | fcnt_a[0], 0);
    chk({tag, " cnt1"}, scnt_a[1] | fcnt_a[1], 0);
    chk({tag, " cnt2"}, {scnt2, fcnt2}, 0);
  endtask

  initial begin
    // rows: D inputs + b | stall flush npc e1 e2 d1 dmw wbe {alu1,alu2,jb}
    tbl[0]  = mk(1, OP_R,      0, 0,  5, 1, 2, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[1]  = mk(1, OP_R,      0, 1,  6, 5, 3, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[2]  = mk(0, 0,         0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 2, 0, 4'b0000, 0, 3'b000);
    tbl[3]  = mk(1, OP_R,      6, 0, 11, 6, 5, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 1, 3'b000);
    tbl[4]  = mk(0, 0,         0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 2, 0, 4'b0000, 1, 3'b000);
    tbl[5]  = mk(1, OP_LOAD,   2, 0,  7, 1, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[6]  = mk(1, OP_R,      0, 0,  8, 7, 7, 0,  1, 0, 1, 2, 2, 0, 4'b0000, 1, 3'b010);
    tbl[7]  = mk(1, OP_R,      0, 0,  8, 7, 7, 0,  0, 0, 1, 1, 1, 0, 4'b0000, 0, 3'b000);
    tbl[8]  = mk(1, OP_BRANCH, 0, 0,  0, 8, 0, 0,  0, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b000);
    tbl[9]  = mk(1, OP_STORE,  2, 0,  0, 2, 8, 0,  0, 0, 1, 1, 2, 0, 4'b0000, 0, 3'b001);
    tbl[10] = mk(1, OP_BRANCH, 0, 0,  0, 8, 2, 1,  0, 0, 1, 2, 0, 1, 4'b0000, 1, 3'b010);
    tbl[11] = mk(1, OP_IMM,    0, 0, 12, 1, 0, 1,  0, 1, 0, 2, 2, 0, 4'b1111, 0, 3'b001);
    tbl[12] = mk(1, OP_STORE,  0, 0,  0, 4, 3, 1,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[13] = mk(1, OP_STORE,  1, 0,  0, 4, 3, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b010);
    tbl[14] = mk(1, OP_STORE,  3, 0,  0, 4, 3, 0,  0, 0, 1, 2, 2, 0, 4'b0001, 0, 3'b010);
    tbl[15] = mk(1, OP_JAL,    0, 0,  0, 0, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0011, 0, 3'b010);
    tbl[16] = mk(1, OP_IMM,    0, 0, 13, 0, 0, 0,  0, 1, 0, 2, 2, 0, 4'b0000, 0, 3'b101);
    tbl[17] = mk(1, OP_R,      0, 0,  0, 1, 2, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[18] = mk(0, 0,         0, 0,  0, 0, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[19] = mk(0, 0,         0, 0,  0, 0, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[20] = mk(1, OP_JALR,   0, 0,  1, 2, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b000);
    tbl[21] = mk(1, OP_R,      0, 0,  3, 1, 1, 0,  0, 1, 0, 2, 2, 0, 4'b0000, 0, 3'b100);
    tbl[22] = mk(1, OP_LUI,    0, 0,  4, 0, 0, 0,  0, 0, 1, 1, 1, 0, 4'b0000, 0, 3'b000);
    tbl[23] = mk(1, OP_AUIPC,  0, 0,  5, 0, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 1, 3'b010);
    tbl[24] = mk(0, 0,         0, 0,  0, 0, 0, 0,  0, 0, 1, 2, 2, 0, 4'b0000, 0, 3'b110);

    // Clock/reset: hold reset across two edges, check the cleared state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    cyc();

    // Table: forwarding, load-use, branches, jumps, stores, x0 writes (instance 0)
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].rs1,
            tbl[i].rs2, tbl[i].bb, 0);
      #2;
      chk($sformatf("row%0d stall", i), stall_o[0], tbl[i].stall);
      chk($sformatf("row%0d flush", i), flush_o[0], tbl[i].flush);
      chk($sformatf("row%0d npc", i), npc_o[0], tbl[i].npc);
      chk($sformatf("row%0d e1", i), e1_o[0], tbl[i].e1);
      chk($sformatf("row%0d e2", i), e2_o[0], tbl[i].e2);
      chk($sformatf("row%0d d1", i), d1_o[0], tbl[i].d1);
      chk($sformatf("row%0d dmw", i), dmw_o[0], tbl[i].dmw);
      chk($sformatf("row%0d wbe", i), wbe_o[0], tbl[i].wbe);
      chk($sformatf("row%0d osel", i), {alu1_o[0], alu2_o[0], jb_o[0]}, tbl[i].osel);
      cyc();
    end
    chk("tbl stall_cnt", scnt_a[0], 1);
    chk("tbl flush_cnt", fcnt_a[0], 3);

    // Load-use with 1 vs 2 bubbles: lw x7 then add x8,x7,x7
    do_reset();
    drive(1, OP_LOAD, 2, 0, 7, 1, 0, 0, 0);
    cyc();
    drive(1, OP_R, 0, 0, 8, 7, 7, 0, 0);
    #2;
    chk("lu2 c1 stall1", stall_o[1], 1);
    chk("lu2 c1 stall0", stall_o[0], 1);
    cyc();
    #2;
    chk("lu2 c2 stall1", stall_o[1], 1);
    chk("lu2 c2 e1", e1_o[1], SEL_M);
    chk("lu2 c2 stall0", stall_o[0], 0);
    cyc();
    #2;
    chk("lu2 c3 stall1", stall_o[1], 0);
    chk("lu2 c3 e1", e1_o[1], SEL_W);
    chk("lu2 c3 d1", d1_o[1], 1);
    chk("lu2 c3 wbsel", wbsel_o[1], 1);
    chk("lu2 c3 scnt1", scnt_a[1], 2);
    chk("lu2 c3 scnt0", scnt_a[0], 1);
    chk("lu2 c3 stall0", stall_o[0], 0);
    cyc();

    // Hold for 3 cycles during a load-use stall (instance 0)
    do_reset();
    drive(1, OP_LOAD, 2, 0, 7, 1, 0, 0, 0);
    cyc();
    drive(1, OP_R, 0, 0, 8, 7, 7, 0, 1);
    for (int h = 0; h < 3; h++) begin
      #2;
      chk($sformatf("hold%0d stall", h), stall_o[0], 1);
      chk($sformatf("hold%0d scnt", h), scnt_a[0], 0);
      chk($sformatf("hold%0d e_f3", h), ef3_o[0], 3'b010);
      cyc();
    end
    hold = 1'b0;
    #2;
    chk("unhold stall", stall_o[0], 1);
    cyc();
    #2;
    chk("unhold+1 stall", stall_o[0], 0);
    chk("unhold+1 scnt", scnt_a[0], 1);
    chk("unhold+1 e1", e1_o[0], SEL_M);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("unhold+2 eop", eop_o[0], OP_R);
    chk("unhold+2 e1", e1_o[0], SEL_W);
    cyc();

    // No forwarding: RAW stalls until producer reaches W; 2-bit counter saturates
    do_reset();
    drive(1, OP_R, 0, 0, 5, 1, 2, 0, 0);
    cyc();
    drive(1, OP_R, 0, 1, 6, 5, 3, 0, 0);
    #2;
    chk("raw c1 stall", stall_o[2], 1);
    cyc();
    #2;
    chk("raw c2 stall", stall_o[2], 1);
    chk("raw c2 e1", e1_o[2], SEL_RF);
    cyc();
    #2;
    chk("raw c3 stall", stall_o[2], 0);
    chk("raw c3 d1", d1_o[2], 1);
    chk("raw c3 scnt", scnt2, 2);
    cyc();
    drive(1, OP_R, 0, 0, 7, 6, 6, 0, 0);
    #2;
    chk("raw c4 stall", stall_o[2], 1);
    chk("raw c4 e1", e1_o[2], SEL_RF);
    cyc();
    #2;
    chk("raw c5 stall", stall_o[2], 1);
    cyc();
    #2;
    chk("raw c6 stall", stall_o[2], 0);
    chk("raw sat scnt", scnt2, 2'b11);
    cyc();
    drive(1, OP_R, 0, 0, 9, 7, 7, 0, 0);
    #2;
    chk("mid stall", stall_o[2], 1);

    // Asynchronous reset mid-stream, then a fresh instruction sees no hazard
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    cyc();
    rst_n = 1'b1;
    drive(1, OP_R, 0, 0, 1, 2, 3, 0, 0);
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("post[%0d] stall", k), stall_o[k], 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("post eop", eop_o[0], OP_R);
    chk("post e1", e1_o[0], SEL_RF);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
